axi_rd_burst_gen: RTL and testbench

//  Upstream stage that feeds one slave port of the 5-slave/1-master AXI request mux.
//  - Accepts a byte-granular read command: start address plus length.
//  - Splits it into INCR AR bursts that never cross a 4KB boundary and never exceed MAX_BURST beats.
//  - Bounds the number of bursts in flight and checks rlast against the issued length of each burst.
//  - Returns the read data as a stream, with a whole-command last flag and a done pulse.

---
 rtl/axi_bfm_pkg.sv | 27 ++
 rtl/axi_rd_len_fifo.sv | 57 +++++
 rtl/axi_rd_burst_gen.sv | 191 +++++++++++++++++++
 tb/tb_axi_rd_burst_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bfm_pkg.sv
// Shared types and helpers for the AXI read-burst BFM blocks.
package axi_bfm_pkg;

  localparam int unsigned AXI_4K = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Beats in the next burst: limited by remaining beats, max burst and the next 4KB boundary.
  function automatic logic [8:0] burst_len(input logic [63:0]   beats_left,
                                           input logic [11:0]   addr_lo,
                                           input int unsigned   align,
                                           input int unsigned   max_burst);
    logic [63:0] n;
    logic [63:0] to_4k;
    to_4k = (64'(AXI_4K) - 64'(addr_lo)) >> align;
    n     = beats_left;
    if (64'(max_burst) < n) n = 64'(max_burst);
    if (to_4k < n)          n = to_4k;
    return 9'(n);
  endfunction

endpackage

// File: rtl/axi_rd_len_fifo.sv
// Small synchronous FIFO holding the arlen of every read burst in flight.
module axi_rd_len_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/axi_rd_burst_gen.sv
// Splits a byte-granular read command into 4KB-safe INCR AR bursts and streams back the R data.
module axi_rd_burst_gen
  import axi_bfm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH   = 32,
  parameter int unsigned MAX_BURST   = 64,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_bytes,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned ALIGN = $clog2(BYTES);
  localparam int unsigned CW    = LEN_WIDTH - ALIGN + 1;
  localparam int unsigned OW    = $clog2(OUTSTANDING) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, araddr_q, araddr_d;
  logic [CW-1:0]         beats_left_q, beats_left_d, total_q, total_d;
  logic [CW-1:0]         rcv_cnt_q, rcv_cnt_d, bib_q, bib_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  arvalid_q, arvalid_d, cmd_ready_q, cmd_ready_d;
  logic                  done_q, done_d, err_q, err_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]            fifo_head;
  logic                  active, beat, ar_hs, cmd_hs, exp_last, rlast_dec;
  logic [8:0]            n;

  assign active    = (state_q != IDLE);
  assign rready    = out_ready & active;
  assign beat      = rvalid & rready;
  assign ar_hs     = arvalid_q & arready;
  assign cmd_hs    = cmd_valid & cmd_ready_q;
  assign exp_last  = !fifo_empty && (bib_q == CW'(fifo_head));
  assign rlast_dec = beat & rlast & (outst_q != '0);
  assign n         = burst_len(64'(beats_left_q), addr_q[11:0], ALIGN, MAX_BURST);

  assign out_data  = rdata;
  assign out_valid = rvalid & active;
  assign out_last  = out_valid & (rcv_cnt_q == total_q - CW'(1));

  assign cmd_ready = cmd_ready_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arvalid   = arvalid_q;
  assign done      = done_q;
  assign err       = err_q;

  axi_rd_len_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (8)
  ) u_len_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (arlen_q),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    total_d      = total_q;
    rcv_cnt_d    = rcv_cnt_q;
    bib_d        = bib_q;
    outst_d      = outst_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    err_d        = err_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d       = cmd_addr;
          beats_left_d = CW'(cmd_bytes >> ALIGN);
          total_d      = CW'(cmd_bytes >> ALIGN);
          rcv_cnt_d    = '0;
          bib_d        = '0;
          err_d        = 1'b0;
          state_d      = (CW'(cmd_bytes >> ALIGN) == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          addr_d       = addr_q + ((ADDR_WIDTH'(arlen_q) + ADDR_WIDTH'(1)) << ALIGN);
          beats_left_d = beats_left_q - (CW'(arlen_q) + CW'(1));
          arvalid_d    = 1'b0;
          fifo_push    = 1'b1;
          if (beats_left_d == '0) state_d = DRAIN;
        end else if (!arvalid_q && (outst_q < OW'(OUTSTANDING)) && !fifo_full &&
                     (beats_left_q != '0)) begin
          araddr_d  = addr_q;
          arlen_d   = 8'(n - 9'd1);
          arvalid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (rcv_cnt_q == total_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // R beat bookkeeping: length check against the FIFO head, data always forwarded.
    if (beat) begin
      rcv_cnt_d = rcv_cnt_q + CW'(1);
      if (fifo_empty) begin
        err_d = 1'b1;
      end else begin
        if (rlast != exp_last) err_d = 1'b1;
        if (exp_last) begin
          fifo_pop = 1'b1;
          bib_d    = '0;
        end else begin
          bib_d = bib_q + CW'(1);
        end
      end
    end

    if (ar_hs && !rlast_dec)      outst_d = outst_q + OW'(1);
    else if (!ar_hs && rlast_dec) outst_d = outst_q - OW'(1);

    done_d      = (state_d == DONE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      total_q      <= '0;
      rcv_cnt_q    <= '0;
      bib_q        <= '0;
      outst_q      <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      total_q      <= total_d;
      rcv_cnt_q    <= rcv_cnt_d;
      bib_q        <= bib_d;
      outst_q      <= outst_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// Directed self-checking bench for axi_rd_burst_gen (512-bit data, 2 bursts in flight).
module tb_axi_rd_burst_gen;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 64;
  localparam int unsigned LW = 32;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_bytes;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  axi_rd_burst_gen #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .LEN_WIDTH   (LW),
    .MAX_BURST   (64),
    .OUTSTANDING (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_bytes (cmd_bytes),
    .araddr    (araddr),
    .arlen     (arlen),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_bytes = b;
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ar_accept();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        cyc = i;
        break;
      end
      tick();
    end
  endtask

  // Streams nb beats with out_ready high; reports payload errors and where out_last appeared.
  task automatic stream_beats(input int nb, input logic [63:0] rlast_map,
                              output int data_bad, output int last_at);
    data_bad = 0;
    last_at  = -1;
    for (int i = 0; i < nb; i++) begin
      out_ready = 1'b1;
      rvalid    = 1'b1;
      rdata     = DW'(i * 7 + 3);
      rlast     = rlast_map[i];
      #1;
      if (!out_valid || out_data !== rdata || !rready) data_bad++;
      if (out_last) last_at = (last_at == -1) ? i : -2;
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({cmd_ready, arvalid, rready, out_valid, out_last, done, err} !== 7'b0 ||
        araddr !== '0 || arlen !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: flags=%b araddr=%h arlen=%0d required all 0",
               {cmd_ready, arvalid, rready, out_valid, out_last, done, err}, araddr, arlen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || arvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: cmd_ready=%b arvalid=%b required 1/0", cmd_ready, arvalid);
    end
  endtask

  task automatic test_single_burst();
    bit ok;
    int dbad, lat;
    send_cmd(64'h0, 32'd4096, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_cmd: cmd_ready=%b required 1", cmd_ready); end
    wait_ar(ok);
    total++;
    if (!ok || araddr !== 64'h0 || arlen !== 8'd63) begin
      bad++;
      $display("FAIL single_ar: arvalid=%b araddr=%h arlen=%0d required 1/0/63", arvalid, araddr, arlen);
    end
    ar_accept();
    stream_beats(64, 64'h8000_0000_0000_0000, dbad, lat);
    total++;
    if (dbad != 0) begin bad++; $display("FAIL single_data: bad_beats=%0d required 0", dbad); end
    total++;
    if (lat != 63) begin bad++; $display("FAIL single_last: out_last_at=%0d required 63", lat); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL single_done_early: done=%b required 0", done); end
    tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL single_done: done=%b required 1", done); end
    tick();
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: done=%b cmd_ready=%b err=%b required 0/1/0", done, cmd_ready, err);
    end
  endtask

  task automatic test_4k_split();
    bit ok;
    int dbad, lat, cyc;
    send_cmd(64'hFC0, 32'd256, ok);
    wait_ar(ok);
    total++;
    if (!ok || araddr !== 64'hFC0 || arlen !== 8'd0) begin
      bad++;
      $display("FAIL split_ar0: arvalid=%b araddr=%h arlen=%0d required 1/fc0/0", arvalid, araddr, arlen);
    end
    ar_accept();
    wait_ar(ok);
    total++;
    if (!ok || araddr !== 64'h1000 || arlen !== 8'd2) begin
      bad++;
      $display("FAIL split_ar1: arvalid=%b araddr=%h arlen=%0d required 1/1000/2", arvalid, araddr, arlen);
    end
    ar_accept();
    stream_beats(4, 64'h9, dbad, lat);
    total++;
    if (dbad != 0 || lat != 3) begin
      bad++;
      $display("FAIL split_data: bad_beats=%0d out_last_at=%0d required 0/3", dbad, lat);
    end
    wait_done(cyc);
    total++;
    if (cyc != 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL split_done: done_after=%0d err=%b required 1/0", cyc, err);
    end
  endtask

  task automatic test_zero_bytes();
    bit ok;
    send_cmd(64'h40, 32'd0, ok);
    total++;
    if (!ok || done !== 1'b1 || arvalid !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: accepted=%b done=%b arvalid=%b required 1/1/0", ok, done, arvalid);
    end
    tick();
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || arvalid !== 1'b0) begin
      bad++;
      $display("FAIL zero_idle: done=%b cmd_ready=%b arvalid=%b required 0/1/0", done, cmd_ready, arvalid);
    end
  endtask

  task automatic test_outstanding();
    bit ok;
    int unstable, extra;
    send_cmd(64'h0, 32'd16384, ok);
    wait_ar(ok);
    total++;
    if (!ok || araddr !== 64'h0 || arlen !== 8'd63) begin
      bad++;
      $display("FAIL outst_ar0: arvalid=%b araddr=%h arlen=%0d required 1/0/63", arvalid, araddr, arlen);
    end
    ar_accept();
    wait_ar(ok);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (arvalid !== 1'b1 || araddr !== 64'h1000 || arlen !== 8'd63) unstable++;
      tick();
    end
    total++;
    if (!ok || unstable != 0) begin
      bad++;
      $display("FAIL outst_stable: seen=%b unstable_cycles=%0d required 1/0", ok, unstable);
    end
    ar_accept();
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (arvalid) extra++;
      tick();
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL outst_limit: arvalid_cycles=%0d required 0", extra);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_toggle_err();
    bit ok;
    int k, cyc, viol;
    send_cmd(64'h0, 32'd512, ok);
    wait_ar(ok);
    total++;
    if (!ok || araddr !== 64'h0 || arlen !== 8'd7) begin
      bad++;
      $display("FAIL toggle_ar: arvalid=%b araddr=%h arlen=%0d required 1/0/7", arvalid, araddr, arlen);
    end
    ar_accept();
    k = 0;
    viol = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      out_ready = c[0];
      rvalid    = 1'b1;
      rdata     = DW'(k + 100);
      rlast     = (k == 3 || k == 7);
      #1;
      if (rready !== out_ready || out_valid !== 1'b1 || out_data !== rdata ||
          out_last !== (k == 7)) viol++;
      tick();
      if (out_ready) k++;
    end
    rvalid    = 1'b0;
    rlast     = 1'b0;
    out_ready = 1'b1;
    total++;
    if (viol != 0 || k != 8) begin
      bad++;
      $display("FAIL toggle_stream: bad_cycles=%0d beats=%0d required 0/8", viol, k);
    end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL toggle_err_set: err=%b required 1", err); end
    wait_done(cyc);
    total++;
    if (cyc != 1 || err !== 1'b1) begin
      bad++;
      $display("FAIL toggle_err_sticky: done_after=%0d err=%b required 1/1", cyc, err);
    end
    send_cmd(64'h80, 32'd0, ok);
    total++;
    if (!ok || err !== 1'b0) begin
      bad++;
      $display("FAIL toggle_err_clear: accepted=%b err=%b required 1/0", ok, err);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int dbad, lat, cyc;
    send_cmd(64'h2000, 32'd1024, ok);
    wait_ar(ok);
    total++;
    if (!ok || araddr !== 64'h2000 || arlen !== 8'd15) begin
      bad++;
      $display("FAIL rst_ar: arvalid=%b araddr=%h arlen=%0d required 1/2000/15", arvalid, araddr, arlen);
    end
    ar_accept();
    stream_beats(5, 64'h0, dbad, lat);
    rvalid    = 1'b1;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, arvalid, rready, out_valid, out_last, done, err} !== 7'b0 ||
        araddr !== '0 || arlen !== 8'd0) begin
      bad++;
      $display("FAIL rst_async: flags=%b araddr=%h arlen=%0d required all 0",
               {cmd_ready, arvalid, rready, out_valid, out_last, done, err}, araddr, arlen);
    end
    rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_cmd(64'h0, 32'd128, ok);
    wait_ar(ok);
    total++;
    if (!ok || araddr !== 64'h0 || arlen !== 8'd1) begin
      bad++;
      $display("FAIL rst_new_ar: arvalid=%b araddr=%h arlen=%0d required 1/0/1", arvalid, araddr, arlen);
    end
    ar_accept();
    stream_beats(2, 64'h2, dbad, lat);
    wait_done(cyc);
    total++;
    if (dbad != 0 || lat != 1 || cyc != 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL rst_new_cmd: bad_beats=%0d last_at=%0d done_after=%0d err=%b required 0/1/1/0",
               dbad, lat, cyc, err);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_bytes = '0;
    arready   = 1'b0;
    rdata     = '0;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    out_ready = 1'b1;

    test_reset();
    test_single_burst();
    test_4k_split();
    test_zero_bytes();
    test_outstanding();
    test_toggle_err();
    test_reset_mid_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
